// File: rtl/booth_iter_counter.sv
// ---------------------------------------------------------------------------
// booth_iter_counter
// Iteration counter for the Booth multiplier datapath. Loads an iteration
// count (DEFAULT_LOAD or a runtime value) and steps it down by STEP on each
// decr. It flags the final iteration, pulses done at terminal count, and can
// reload itself for back-to-back multiplies.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   ld_count     load strobe; highest priority
//   use_default  1: load DEFAULT_LOAD, 0: load ld_val
//   ld_val       runtime load value
//   decr         decrement request, one step per cycle high
//   count        current count (registered)
//   busy         high while in RUN (registered)
//   zero         count == 0 (combinational)
//   last         busy && count <= STEP; the next decr terminates
//   done         one-cycle terminal / zero-load pulse (registered)
//   decr_err     sticky: decr seen while idle; cleared by load (registered)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no iteration in progress; decr here raises decr_err
// ST_RUN  | counting down; terminal decr ends the run or reloads it
// ---------------------------------------------------------------------------
module booth_iter_counter #(
   parameter int WIDTH        = 4,
   parameter int DEFAULT_LOAD = 4,
   parameter int STEP         = 1,
   parameter int AUTO_RELOAD  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_count,
   input  logic             use_default,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             decr,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             zero,
   output logic             last,
   output logic             done,
   output logic             decr_err
);

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [WIDTH-1:0] DEF_L  = WIDTH'(DEFAULT_LOAD);
   localparam logic [WIDTH-1:0] STEP_L = WIDTH'(STEP);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic [WIDTH-1:0] reload, reload_nxt;
   logic             done_nxt;
   logic             err_nxt;
   logic [WIDTH-1:0] load_val;

   assign load_val = use_default ? DEF_L : ld_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         count    <= '0;
         reload   <= '0;
         done     <= 1'b0;
         decr_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         count    <= count_nxt;
         reload   <= reload_nxt;
         done     <= done_nxt;
         decr_err <= err_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      reload_nxt = reload;
      done_nxt   = 1'b0;
      err_nxt    = decr_err;
      if (ld_count) begin
         // A coincident decr is dropped without flagging an error.
         count_nxt  = load_val;
         reload_nxt = load_val;
         err_nxt    = 1'b0;
         if (load_val != '0) begin
            state_nxt = ST_RUN;
         end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
         end
      end else if (decr) begin
         if (state == ST_RUN) begin
            if (count > STEP_L) begin
               count_nxt = count - STEP_L;
            end else begin
               // Terminal: saturate rather than wrap.
               done_nxt = 1'b1;
               if (AUTO_RELOAD != 0) begin
                  count_nxt = reload;
               end else begin
                  count_nxt = '0;
                  state_nxt = ST_IDLE;
               end
            end
         end else begin
            err_nxt = 1'b1;
         end
      end
   end

   assign busy = (state == ST_RUN);
   assign zero = (count == '0);
   assign last = busy && (count <= STEP_L);

endmodule
